// File: rtl/fft_sched_pkg.sv
// Shared types and helpers for the radix-2 DIT butterfly scheduler.
package fft_sched_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // Working width of insert_bit; comfortably above the largest legal LOGN.
  localparam int unsigned IB_W = 16;

  // Twiddle index width: LOGN-1 bits, never narrower than one bit.
  function automatic int tw_width(input int logn);
    return (logn > 1) ? logn - 1 : 1;
  endfunction

  // Splice bitval into value at position pos; bits at and above pos move up one.
  function automatic logic [IB_W-1:0] insert_bit(input logic [IB_W-1:0] value,
                                                 input int unsigned     pos,
                                                 input logic            bitval);
    logic [IB_W-1:0] lo_mask;
    lo_mask = (IB_W'(1) << pos) - IB_W'(1);
    return ((value & ~lo_mask) << 1) | (IB_W'(bitval) << pos) | (value & lo_mask);
  endfunction

endpackage

// File: rtl/fft_bfly_addr_gen.sv
// Combinational (stage, butterfly) -> operand addresses and twiddle index.
module fft_bfly_addr_gen
  import fft_sched_pkg::*;
#(
  parameter  int LOGN = 3,
  localparam int N    = 2 ** LOGN,
  localparam int KW   = tw_width(LOGN),
  localparam int TW_W = tw_width(LOGN)
) (
  input  logic [LOGN-1:0] i_s,
  input  logic [KW-1:0]   i_k,
  output logic [LOGN-1:0] o_addr_a,
  output logic [LOGN-1:0] o_addr_b,
  output logic [TW_W-1:0] o_tw_idx,
  output logic            o_last_k,
  output logic            o_last_s
);

  // Pair partners differ only in bit s; twiddle uses k's low s bits scaled to W_N.
  always_comb begin
    o_addr_a = LOGN'(insert_bit(IB_W'(i_k), 32'(i_s), 1'b0));
    o_addr_b = LOGN'(insert_bit(IB_W'(i_k), 32'(i_s), 1'b1));
    o_tw_idx = TW_W'((32'(i_k) & ((32'd1 << i_s) - 32'd1)) << (32'(LOGN - 1) - 32'(i_s)));
    o_last_k = (i_k == KW'(N / 2 - 1));
    o_last_s = (i_s == LOGN'(LOGN - 1));
  end

endmodule

// File: rtl/fft_bfly_sched.sv
// Sequencer for one radix-2 butterfly: walks every stage/butterfly of an
// in-place N-point DIT FFT, one butterfly in flight at a time.
module fft_bfly_sched
  import fft_sched_pkg::*;
#(
  parameter  int LOGN = 3,
  localparam int N    = 2 ** LOGN,
  localparam int TW_W = tw_width(LOGN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_val,
  output logic            start_rdy,
  output logic            done_val,
  input  logic            done_rdy,
  output logic [LOGN-1:0] addr_a,
  output logic [LOGN-1:0] addr_b,
  output logic [TW_W-1:0] tw_idx,
  output logic            bf_recv_val,
  input  logic            bf_recv_rdy,
  input  logic            bf_send_val,
  output logic            bf_send_rdy,
  output logic            wr_en,
  output logic [LOGN-1:0] stage,
  output logic            busy
);

  localparam int KW = tw_width(LOGN);

  state_t          r_state, w_next;
  logic [LOGN-1:0] r_s;
  logic [KW-1:0]   r_k;
  logic            w_clr, w_k_inc, w_s_inc;
  logic [LOGN-1:0] w_addr_a, w_addr_b;
  logic [TW_W-1:0] w_tw_idx;
  logic            w_last_k, w_last_s;

  fft_bfly_addr_gen #(.LOGN(LOGN)) u_addr (
    .i_s      (r_s),
    .i_k      (r_k),
    .o_addr_a (w_addr_a),
    .o_addr_b (w_addr_b),
    .o_tw_idx (w_tw_idx),
    .o_last_k (w_last_k),
    .o_last_s (w_last_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state, handshake outputs and counter controls.
  always_comb begin
    w_next      = r_state;
    start_rdy   = 1'b0;
    done_val    = 1'b0;
    bf_recv_val = 1'b0;
    bf_send_rdy = 1'b0;
    wr_en       = 1'b0;
    busy        = 1'b0;
    w_clr       = 1'b0;
    w_k_inc     = 1'b0;
    w_s_inc     = 1'b0;
    unique case (r_state)
      IDLE: begin
        start_rdy = 1'b1;
        if (start_val) begin
          w_clr  = 1'b1;
          w_next = ISSUE;
        end
      end
      ISSUE: begin
        busy        = 1'b1;
        bf_recv_val = 1'b1;
        if (bf_recv_rdy) w_next = WAIT;
      end
      WAIT: begin
        busy        = 1'b1;
        bf_send_rdy = 1'b1;
        wr_en       = bf_send_val;
        if (bf_send_val) begin
          if (!w_last_k) begin
            w_k_inc = 1'b1;
            w_next  = ISSUE;
          end else if (!w_last_s) begin
            w_s_inc = 1'b1;
            w_next  = ISSUE;
          end else begin
            w_next  = DONE;
          end
        end
      end
      DONE: begin
        done_val = 1'b1;
        if (done_rdy) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Stage / butterfly counters; they only move on a write-back, so the
  // addresses stay frozen through any stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s <= '0;
      r_k <= '0;
    end else if (w_clr) begin
      r_s <= '0;
      r_k <= '0;
    end else if (w_k_inc) begin
      r_k <= r_k + KW'(1);
    end else if (w_s_inc) begin
      r_k <= '0;
      r_s <= r_s + LOGN'(1);
    end
  end

  // Addresses read as zero when no butterfly is active.
  assign addr_a = busy ? w_addr_a : '0;
  assign addr_b = busy ? w_addr_b : '0;
  assign tw_idx = busy ? w_tw_idx : '0;
  assign stage  = r_s;

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Bench for fft_bfly_sched (LOGN=3): spec address table, DIT loop model,
// random butterfly stalls, done back-pressure, mid-run reset, impulse FFT.
module tb_fft_bfly_sched;

  localparam int LOGN   = 3;
  localparam int N      = 2 ** LOGN;
  localparam int TOTAL  = N / 2 * LOGN;
  localparam int MAXCYC = 3000;
  localparam real PI    = 3.14159265358979;

  logic            clk, reset, start_val, done_rdy, bf_recv_rdy, bf_send_val;
  logic            start_rdy, done_val, bf_recv_val, bf_send_rdy, wr_en, busy;
  logic [LOGN-1:0] addr_a, addr_b, stage;
  logic [LOGN-2:0] tw_idx;

  fft_bfly_sched #(.LOGN(LOGN)) dut (
    .clk(clk), .reset(reset), .start_val(start_val), .start_rdy(start_rdy),
    .done_val(done_val), .done_rdy(done_rdy), .addr_a(addr_a), .addr_b(addr_b),
    .tw_idx(tw_idx), .bf_recv_val(bf_recv_val), .bf_recv_rdy(bf_recv_rdy),
    .bf_send_val(bf_send_val), .bf_send_rdy(bf_send_rdy), .wr_en(wr_en),
    .stage(stage), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int idx; int cyc; int a; int b; int tw;
  } vec_t;

  vec_t tbl[TOTAL];
  int   m_a[TOTAL], m_b[TOTAL], m_tw[TOTAL];
  int   exp_a[TOTAL], exp_b[TOTAL], exp_tw[TOTAL];
  int   mem_re[N], mem_im[N], rom_re[N/2], rom_im[N/2];
  int   n_tests, n_fail;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int qmul(input int x, input int y);
    longint p;
    p = longint'(x) * longint'(y);
    return int'(p >>> 16);
  endfunction

  // Textbook DIT ordering: per stage, group-major, span doubles each stage.
  function automatic void build_model();
    int n;
    n = 0;
    for (int s = 0; s < LOGN; s++) begin
      for (int g = 0; g < N; g += (2 << s)) begin
        for (int j = 0; j < (1 << s); j++) begin
          m_a[n]  = g + j;
          m_b[n]  = g + j + (1 << s);
          m_tw[n] = j * (N / (2 << s));
          n++;
        end
      end
    end
  endfunction

  task automatic check_reset(input string nm);
    check({nm, "_start_rdy"}, int'(start_rdy), 1);
    check({nm, "_done_val"},  int'(done_val), 0);
    check({nm, "_recv_val"},  int'(bf_recv_val), 0);
    check({nm, "_send_rdy"},  int'(bf_send_rdy), 0);
    check({nm, "_wr_en"},     int'(wr_en), 0);
    check({nm, "_busy"},      int'(busy), 0);
    check({nm, "_addr_a"},    int'(addr_a), 0);
    check({nm, "_addr_b"},    int'(addr_b), 0);
    check({nm, "_tw_idx"},    int'(tw_idx), 0);
    check({nm, "_stage"},     int'(stage), 0);
  endtask

  // One FFT: starts the DUT, plays the butterfly with random stalls up to
  // rmax/smax, keeps the sample memory, optionally resets at butterfly abort_at.
  task automatic run_fft(input int rmax, input int smax, input bit timing, input int abort_at);
    int cur, cyc, phase, rstall, sstall;
    int c_re, c_im, d_re, d_im, t_re, t_im;
    for (int i = 0; i < N; i++) begin mem_re[i] = 0; mem_im[i] = 0; end
    mem_re[0] = 32'h0001_0000;
    cur = 0; phase = 0; cyc = 1;
    rstall = int'($urandom_range(rmax, 0)); sstall = 0;
    c_re = 0; c_im = 0; d_re = 0; d_im = 0;
    @(negedge clk);
    check("idle_start_rdy", int'(start_rdy), 1);
    start_val = 1'b1;
    @(posedge clk);
    while (cur < TOTAL && cyc < MAXCYC) begin
      @(negedge clk);
      start_val = 1'b0; bf_recv_rdy = 1'b0; bf_send_val = 1'b0;
      if (phase == 1 && cur == abort_at) begin
        bf_send_val = 1'b1;
        #1 reset = 1'b1;
        #1 check_reset("abort");
        @(negedge clk);
        reset = 1'b0; bf_send_val = 1'b0;
        return;
      end
      if (phase == 0) begin
        if (rstall > 0) rstall--; else bf_recv_rdy = 1'b1;
      end else begin
        if (sstall > 0) sstall--; else bf_send_val = 1'b1;
      end
      #1;
      check("busy", int'(busy), 1);
      check("start_rdy_busy", int'(start_rdy), 0);
      check("done_val_busy", int'(done_val), 0);
      check("recv_val", int'(bf_recv_val), int'(phase == 0));
      check("send_rdy", int'(bf_send_rdy), int'(phase == 1));
      check("wr_en", int'(wr_en), int'(phase == 1 && bf_send_val));
      check("addr_a", int'(addr_a), exp_a[cur]);
      check("addr_b", int'(addr_b), exp_b[cur]);
      check("tw_idx", int'(tw_idx), exp_tw[cur]);
      check("stage", int'(stage), cur / (N / 2));
      if (phase == 0 && bf_recv_rdy) begin
        if (timing) check("issue_cyc", cyc, tbl[cur].cyc);
        t_re = qmul(mem_re[addr_b], rom_re[tw_idx]) - qmul(mem_im[addr_b], rom_im[tw_idx]);
        t_im = qmul(mem_re[addr_b], rom_im[tw_idx]) + qmul(mem_im[addr_b], rom_re[tw_idx]);
        c_re = mem_re[addr_a] + t_re; c_im = mem_im[addr_a] + t_im;
        d_re = mem_re[addr_a] - t_re; d_im = mem_im[addr_a] - t_im;
        sstall = int'($urandom_range(smax, 0));
        phase = 1;
      end else if (phase == 1 && bf_send_val) begin
        mem_re[addr_a] = c_re; mem_im[addr_a] = c_im;
        mem_re[addr_b] = d_re; mem_im[addr_b] = d_im;
        cur++;
        rstall = int'($urandom_range(rmax, 0));
        phase = 0;
      end
      @(posedge clk);
      cyc++;
    end
    check("writebacks", cur, TOTAL);
    @(negedge clk);
    bf_recv_rdy = 1'b0; bf_send_val = 1'b0;
    #1;
    check("done_val", int'(done_val), 1);
    check("done_busy", int'(busy), 0);
    check("done_start_rdy", int'(start_rdy), 0);
    if (timing) check("done_cyc", cyc, N * LOGN + 1);
    for (int i = 0; i < N; i++) begin
      check("bin_re", mem_re[i], 32'h0001_0000);
      check("bin_im", mem_im[i], 0);
    end
  endtask

  // Completion handshake after `hold` cycles of done_rdy low; a start pulse
  // during DONE and one coincident with acceptance must both be ignored.
  task automatic done_accept(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      done_rdy = 1'b0; start_val = (i == 2);
      #1;
      check("hold_done_val", int'(done_val), 1);
      check("hold_start_rdy", int'(start_rdy), 0);
      check("hold_busy", int'(busy), 0);
    end
    @(negedge clk);
    done_rdy = 1'b1; start_val = 1'b1;
    #1 check("accept_done_val", int'(done_val), 1);
    @(negedge clk);
    done_rdy = 1'b0; start_val = 1'b0;
    #1;
    check("post_start_rdy", int'(start_rdy), 1);
    check("post_done_val", int'(done_val), 0);
    check("post_busy", int'(busy), 0);
    @(negedge clk);
    #1;
    check("no_restart_busy", int'(busy), 0);
    check("no_restart_rdy", int'(start_rdy), 1);
  endtask

  task automatic use_table();
    for (int i = 0; i < TOTAL; i++) begin
      exp_a[i] = tbl[i].a; exp_b[i] = tbl[i].b; exp_tw[i] = tbl[i].tw;
    end
  endtask

  task automatic use_model();
    for (int i = 0; i < TOTAL; i++) begin
      exp_a[i] = m_a[i]; exp_b[i] = m_b[i]; exp_tw[i] = m_tw[i];
    end
  endtask

  initial begin
    int ta[TOTAL], tb_[TOTAL], tt[TOTAL];
    n_tests = 0; n_fail = 0;
    reset = 1'b1; start_val = 1'b0; done_rdy = 1'b0;
    bf_recv_rdy = 1'b0; bf_send_val = 1'b0;

    ta  = '{0,2,4,6, 0,1,4,5, 0,1,2,3};
    tb_ = '{1,3,5,7, 2,3,6,7, 4,5,6,7};
    tt  = '{0,0,0,0, 0,2,0,2, 0,1,2,3};
    for (int i = 0; i < TOTAL; i++)
      tbl[i] = '{idx: i, cyc: 1 + 2 * i, a: ta[i], b: tb_[i], tw: tt[i]};
    for (int k = 0; k < N / 2; k++) begin
      rom_re[k] = $rtoi($cos(2.0 * PI * k / N) * 65536.0);
      rom_im[k] = -$rtoi($sin(2.0 * PI * k / N) * 65536.0);
    end
    build_model();

    #1 check_reset("por");
    @(negedge clk);
    reset = 1'b0;
    #1 check_reset("idle");

    // Zero-latency butterfly against the spec table, then stalled completion.
    use_table();
    run_fft(0, 0, 1'b1, -1);
    done_accept(5);

    // Random stalls against the loop model.
    use_model();
    for (int r = 0; r < 4; r++) begin
      run_fft(7, 7, 1'b0, -1);
      done_accept(r);
    end

    // Reset during stage 1 with a result pending, then a clean full run.
    use_table();
    run_fft(0, 0, 1'b0, 5);
    #1 check_reset("after_abort");
    run_fft(0, 0, 1'b1, -1);
    done_accept(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_bfly_sched.md
Name: fft_bfly_sched

Overview:
- Sequencing controller for one radix-2 butterfly unit; runs a full in-place N-point decimation-in-time FFT over an external sample memory.
- Walks every stage and every butterfly in each stage, and drives the memory read/write addresses and the twiddle ROM index.
- Handles the butterfly's val/rdy handshakes; sample data never passes through this block.
- Input samples sit in memory in bit-reversed order; output is natural order. One butterfly is in flight at a time, matching the iterative multiplier inside the butterfly.

Parameters:
- LOGN, 3, log2 of FFT size N; legal range 1..10.
- N, 2**LOGN, FFT size; derived, never overridden.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start_val  in  1  request to run one full FFT
- start_rdy  out  1  high only in IDLE
- done_val  out  1  FFT complete; held until accepted
- done_rdy  in  1  consumer accepts completion
- addr_a  out  LOGN  read/write address of the butterfly "a" (upper) operand
- addr_b  out  LOGN  read/write address of the butterfly "b" (lower) operand
- tw_idx  out  LOGN-1 (min 1)  twiddle ROM index k for W_N^k
- bf_recv_val  out  1  operands valid to butterfly
- bf_recv_rdy  in  1  butterfly can accept operands
- bf_send_val  in  1  butterfly result valid
- bf_send_rdy  out  1  controller accepts result
- wr_en  out  1  write butterfly outputs c->addr_a, d->addr_b this cycle
- stage  out  LOGN bits wide (ceil(log2(LOGN)) significant)  current stage s
- busy  out  1  high in ISSUE or WAIT

Behaviour:
- Reset (async, any state, including mid-FFT):
  - State goes to IDLE; s=0, k=0.
  - Outputs: start_rdy=1, done_val=0, bf_recv_val=0, bf_send_rdy=0, wr_en=0, busy=0, addr_a=0, addr_b=0, tw_idx=0, stage=0.
  - Memory contents after a reset mid-FFT are partially transformed and undefined; no recovery is attempted.
- State registers: state in {IDLE, ISSUE, WAIT, DONE}; stage counter s (0..LOGN-1); butterfly counter k (0..N/2-1).
- Address generation (combinational from s, k):
  - addr_a = k with a 0 bit inserted at bit position s.
  - addr_b = k with a 1 bit inserted at bit position s, i.e. addr_a + 2**s.
  - tw_idx = (k mod 2**s) << (LOGN-1-s), truncated to LOGN-1 bits.
- IDLE:
  - start_rdy=1.
  - On start_val&start_rdy: clear s and k, go to ISSUE.
- ISSUE:
  - bf_recv_val=1; addr_a, addr_b and tw_idx are stable for the whole state, since memory read data feeds the butterfly directly.
  - On bf_recv_rdy: go to WAIT.
- WAIT:
  - bf_send_rdy=1; addresses held unchanged.
  - wr_en = bf_send_val, combinational, same cycle.
  - On bf_send_val:
    - If k < N/2-1: k++ and go to ISSUE.
    - Else if s < LOGN-1: k=0, s++, go to ISSUE.
    - Else: go to DONE.
- DONE:
  - done_val=1.
  - On done_rdy: go to IDLE. done_val&done_rdy and start_val in the same cycle does not start a new run; start is sampled next cycle in IDLE.
- Ordering and hazards:
  - A new butterfly is issued only after the previous write-back cycle.
  - Stage boundaries therefore need no extra hazard logic; RAW ordering is guaranteed.
- start_val outside IDLE is ignored.
- Timing: N/2*LOGN butterflies per FFT. With a butterfly whose recv_rdy=1 and which returns send_val one cycle after the recv handshake, each butterfly takes exactly 2 cycles.
  - Start accepted at edge 0; butterfly i is issued in cycle 1+2i.
  - done_val rises in cycle N*LOGN+1.
- Back-pressure: arbitrary stalls on bf_recv_rdy or delayed bf_send_val only lengthen ISSUE/WAIT. Addresses and tw_idx must not change while stalled.

Decomposition:
- Package fft_sched_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, DONE);
  - a function insert_bit(value, pos, bitval) used for the address computation;
  - the constant for the twiddle index width.
- One sub-module, fft_bfly_addr_gen: purely combinational, (s, k) -> addr_a, addr_b, tw_idx, last_k, last_s.
- The FSM and counters stay in fft_bfly_sched.

Test Plan:
- Reset mid-stage-1 with bf_send_val pending: all outputs return to reset values immediately, with no wr_en; a subsequent start runs the full 12 butterflies.
- LOGN=3, zero-latency butterfly model:
  - (addr_a, addr_b, tw_idx) sequence is stage 0: (0,1,0)(2,3,0)(4,5,0)(6,7,0); stage 1: (0,2,0)(1,3,2)(4,6,0)(5,7,2); stage 2: (0,4,0)(1,5,1)(2,6,2)(3,7,3).
  - Each is issued in cycle 1+2i; done_val is seen in cycle 25.
- Random bf_recv_rdy / bf_send_val stalls (0-7 cycles): identical address sequence; addresses stable during every stall; exactly 12 wr_en pulses.
- done_rdy held low 5 cycles: done_val stays 1, start_rdy stays 0, a start_val pulse is ignored; after acceptance start_rdy=1 next cycle.
- End-to-end: bit-reversed impulse x[0]=1.0 (Q16.16 0x00010000) with a reference butterfly and twiddle ROM: every output bin reads 0x00010000 real, 0 imaginary.
